mac_operand_sequencer: RTL

Control-side driver for the `mac` unit in the NPU datapath. It fetches one neuron's pixel and weight operands from synchronous-read memories and streams them into the MAC as `a`/`b`. It drives the MAC's `EN_MAC`/`RST_MAC` handshake and supplies the bias. It then captures the final `result` as a registered neuron output with a one-cycle valid strobe.

---
 rtl/mac_operand_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mac_operand_sequencer.sv
// Operand sequencer for the NPU MAC: streams pixel/weight pairs, drives the MAC handshake, captures the neuron output.
// Define SEQ_RELU_EN to apply ReLU to the captured MAC result; undefined passes the raw 16-bit result through.
module mac_operand_sequencer #(
    parameter int N_INPUTS = 784,
    parameter int X_ADDR_W = 10,
    parameter int W_ADDR_W = 13
) (
    input  logic                CLKEXT,
    input  logic                RSTN_SEQ,
    input  logic                START,
    input  logic [W_ADDR_W-1:0] W_BASE,
    input  logic [7:0]          BIAS_DATA,
    output logic [X_ADDR_W-1:0] X_ADDR,
    input  logic [7:0]          X_DATA,
    output logic [W_ADDR_W-1:0] W_ADDR,
    input  logic [7:0]          W_DATA,
    output logic                EN_MAC,
    output logic                RST_MAC,
    output logic [7:0]          A_OUT,
    output logic [7:0]          B_OUT,
    output logic [7:0]          BIAS_OUT,
    input  logic [15:0]         MAC_RESULT,
    output logic                BUSY,
    output logic [15:0]         NEURON_OUT,
    output logic                OUT_VALID
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_STREAM  = 3'd2,
        S_FLUSH   = 3'd3,
        S_CAPTURE = 3'd4
    } state_t;

    localparam logic [X_ADDR_W-1:0] LAST_IDX = X_ADDR_W'(N_INPUTS - 1);

    function automatic logic [15:0] neuron_fn(input logic [15:0] x);
`ifdef SEQ_RELU_EN
        if (x[15]) begin
            neuron_fn = 16'd0;
        end else begin
            neuron_fn = x;
        end
`else
        neuron_fn = x;
`endif
    endfunction

    state_t              r_state;
    logic [X_ADDR_W-1:0] r_index;
    logic [W_ADDR_W-1:0] r_w_base;
    logic [7:0]          r_bias;
    logic [X_ADDR_W-1:0] r_x_addr;
    logic [W_ADDR_W-1:0] r_w_addr;
    logic                r_en_mac;
    logic                r_rst_mac;
    logic                r_busy;
    logic                r_out_valid;
    logic [15:0]         r_neuron_out;

    state_t              w_state_nxt;
    logic [X_ADDR_W-1:0] w_index_nxt;
    logic [W_ADDR_W-1:0] w_w_base_nxt;
    logic [7:0]          w_bias_nxt;
    logic [15:0]         w_neuron_nxt;
    logic [X_ADDR_W-1:0] w_x_addr_nxt;
    logic [W_ADDR_W-1:0] w_w_addr_nxt;

    // Next-state, index and job-context update
    always_comb begin
        w_state_nxt  = r_state;
        w_index_nxt  = r_index;
        w_w_base_nxt = r_w_base;
        w_bias_nxt   = r_bias;
        w_neuron_nxt = r_neuron_out;
        case (r_state)
            S_IDLE: begin
                if (START) begin
                    w_state_nxt  = S_CLEAR;
                    w_index_nxt  = {X_ADDR_W{1'b0}};
                    w_w_base_nxt = W_BASE;
                    w_bias_nxt   = BIAS_DATA;
                end else begin
                    w_state_nxt  = S_IDLE;
                end
            end
            S_CLEAR: begin
                w_state_nxt = S_STREAM;
                w_index_nxt = {X_ADDR_W{1'b0}};
            end
            S_STREAM: begin
                if (r_index == LAST_IDX) begin
                    w_state_nxt = S_FLUSH;
                end else begin
                    w_index_nxt = r_index + X_ADDR_W'(1);
                end
            end
            S_FLUSH: begin
                w_state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                w_neuron_nxt = neuron_fn(MAC_RESULT);
                w_state_nxt  = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Addresses are registered, so they are computed from the state being entered
    always_comb begin
        w_x_addr_nxt = {X_ADDR_W{1'b0}};
        w_w_addr_nxt = {W_ADDR_W{1'b0}};
        if (w_state_nxt == S_STREAM) begin
            w_x_addr_nxt = w_index_nxt;
            w_w_addr_nxt = w_w_base_nxt + W_ADDR_W'(w_index_nxt);
        end else begin
            w_x_addr_nxt = {X_ADDR_W{1'b0}};
            w_w_addr_nxt = {W_ADDR_W{1'b0}};
        end
    end

    // State and output registers; EN_MAC trails each address issue by one cycle
    always_ff @(posedge CLKEXT) begin
        if (!RSTN_SEQ) begin
            r_state      <= S_IDLE;
            r_index      <= {X_ADDR_W{1'b0}};
            r_w_base     <= {W_ADDR_W{1'b0}};
            r_bias       <= 8'd0;
            r_x_addr     <= {X_ADDR_W{1'b0}};
            r_w_addr     <= {W_ADDR_W{1'b0}};
            r_en_mac     <= 1'b0;
            r_rst_mac    <= 1'b0;
            r_busy       <= 1'b0;
            r_out_valid  <= 1'b0;
            r_neuron_out <= 16'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_index      <= w_index_nxt;
            r_w_base     <= w_w_base_nxt;
            r_bias       <= w_bias_nxt;
            r_x_addr     <= w_x_addr_nxt;
            r_w_addr     <= w_w_addr_nxt;
            r_en_mac     <= (r_state == S_STREAM);
            r_rst_mac    <= (w_state_nxt == S_CLEAR);
            r_busy       <= (w_state_nxt != S_IDLE);
            r_out_valid  <= (r_state == S_CAPTURE);
            r_neuron_out <= w_neuron_nxt;
        end
    end

    assign X_ADDR     = r_x_addr;
    assign W_ADDR     = r_w_addr;
    assign EN_MAC     = r_en_mac;
    assign RST_MAC    = r_rst_mac;
    assign A_OUT      = X_DATA;
    assign B_OUT      = W_DATA;
    assign BIAS_OUT   = r_bias;
    assign BUSY       = r_busy;
    assign NEURON_OUT = r_neuron_out;
    assign OUT_VALID  = r_out_valid;

endmodule
